// File: rtl/dual_issue_regfile.sv
// Dual-issue 32x32 register file with per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-back forwarding to reads and busy.
module dual_issue_regfile #(
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteWA,
  input  logic        RegWriteWB,
  input  logic [4:0]  WriteRegWA,
  input  logic [4:0]  WriteRegWB,
  input  logic [31:0] ResultWA,
  input  logic [31:0] ResultWB,
  input  logic [4:0]  RsDA,
  input  logic [4:0]  RtDA,
  input  logic [4:0]  RsDB,
  input  logic [4:0]  RtDB,
  output logic [31:0] RD1DA,
  output logic [31:0] RD2DA,
  output logic [31:0] RD1DB,
  output logic [31:0] RD2DB,
  output logic        BusyRsDA,
  output logic        BusyRtDA,
  output logic        BusyRsDB,
  output logic        BusyRtDB,
  input  logic        IssueDA,
  input  logic        IssueDB,
  input  logic [4:0]  DestDA,
  input  logic [4:0]  DestDB,
  output logic        Overflow
);
  localparam int NREG  = 32;
  localparam int NPORT = 4;

  logic [NREG-1:0][31:0]      regs, rview;
  logic [NREG-1:0][CNT_W-1:0] cnt, cnt_nxt;
  logic [NREG-1:0][1:0]       ninc, ndec;
  logic [NREG-1:0][CNT_W+1:0] net;
  logic [NREG-1:0]            bview, wrap;

  // Per-register view: what a read port sees and whether it is busy.
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    localparam logic [4:0] R = 5'(r);
    if (r == 0) begin : g_zero
      assign ninc[r]  = '0;
      assign ndec[r]  = '0;
      assign rview[r] = regs[r];
      assign bview[r] = 1'b0;
    end else begin : g_live
      logic ia_hit, ib_hit, wa_hit, wb_hit;
      assign ia_hit  = IssueDA && (DestDA == R);
      assign ib_hit  = IssueDB && (DestDB == R);
      assign wa_hit  = RegWriteWA && (WriteRegWA == R);
      assign wb_hit  = RegWriteWB && (WriteRegWB == R);
      assign ninc[r] = {1'b0, ia_hit} + {1'b0, ib_hit};
      assign ndec[r] = {1'b0, wa_hit} + {1'b0, wb_hit};
`ifdef REGFILE_BYPASS_EN
      assign rview[r] = wb_hit ? ResultWB : (wa_hit ? ResultWA : regs[r]);
      assign bview[r] = (cnt[r] != CNT_W'(ndec[r]));
`else
      assign rview[r] = regs[r];
      assign bview[r] = (cnt[r] != '0);
`endif
    end
    // Two guard bits catch both wrap directions: underflow goes negative, overflow sets bit CNT_W.
    assign net[r]     = {2'b00, cnt[r]} + {{CNT_W{1'b0}}, ninc[r]} - {{CNT_W{1'b0}}, ndec[r]};
    assign wrap[r]    = |net[r][CNT_W+1:CNT_W];
    assign cnt_nxt[r] = net[r][CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs     <= '0;
      cnt      <= '0;
      Overflow <= 1'b0;
    end else begin
      // Lane B assigned last so it wins on a shared destination.
      if (RegWriteWA && (WriteRegWA != 5'd0)) regs[WriteRegWA] <= ResultWA;
      if (RegWriteWB && (WriteRegWB != 5'd0)) regs[WriteRegWB] <= ResultWB;
      cnt <= cnt_nxt;
      if (|wrap) Overflow <= 1'b1;
    end
  end

  logic [NPORT-1:0][4:0]  raddr;
  logic [NPORT-1:0][31:0] rdata;
  logic [NPORT-1:0]       rbusy;

  assign raddr = {RtDB, RsDB, RtDA, RsDA};

  // Outputs forced quiet while reset is held, independent of any bypass path.
  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    assign rdata[p] = reset ? '0 : rview[raddr[p]];
    assign rbusy[p] = !reset && bview[raddr[p]];
  end

  assign {RD2DB, RD1DB, RD2DA, RD1DA}             = rdata;
  assign {BusyRtDB, BusyRsDB, BusyRtDA, BusyRsDA} = rbusy;
endmodule

// File: tb/tb_dual_issue_regfile.sv
// Directed bench for dual_issue_regfile: vector table plus scoreboard/reset/overflow sequences.
module tb_dual_issue_regfile;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        RegWriteWA, RegWriteWB;
  logic [4:0]  WriteRegWA, WriteRegWB;
  logic [31:0] ResultWA, ResultWB;
  logic [4:0]  RsDA, RtDA, RsDB, RtDB;
  logic [31:0] RD1DA, RD2DA, RD1DB, RD2DB;
  logic        BusyRsDA, BusyRtDA, BusyRsDB, BusyRtDB;
  logic        IssueDA, IssueDB;
  logic [4:0]  DestDA, DestDB;
  logic        Overflow;
  int          total = 0;
  int          bad = 0;

  dual_issue_regfile #(.CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .RegWriteWA(RegWriteWA), .RegWriteWB(RegWriteWB),
    .WriteRegWA(WriteRegWA), .WriteRegWB(WriteRegWB),
    .ResultWA(ResultWA), .ResultWB(ResultWB),
    .RsDA(RsDA), .RtDA(RtDA), .RsDB(RsDB), .RtDB(RtDB),
    .RD1DA(RD1DA), .RD2DA(RD2DA), .RD1DB(RD1DB), .RD2DB(RD2DB),
    .BusyRsDA(BusyRsDA), .BusyRtDA(BusyRtDA), .BusyRsDB(BusyRsDB), .BusyRtDB(BusyRtDB),
    .IssueDA(IssueDA), .IssueDB(IssueDB), .DestDA(DestDA), .DestDB(DestDB),
    .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wea;
    logic [4:0]  wa;
    logic [31:0] da;
    logic        web;
    logic [4:0]  wb;
    logic [31:0] db;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    RegWriteWA = 1'b0; RegWriteWB = 1'b0;
    IssueDA = 1'b0;    IssueDB = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input logic [4:0] a);
    RsDA = a; RtDA = a; RsDB = a; RtDB = a;
    #1;
  endtask

  task automatic wr_a(input logic [4:0] r, input logic [31:0] d);
    RegWriteWA = 1'b1; WriteRegWA = r; ResultWA = d;
  endtask
  task automatic wr_b(input logic [4:0] r, input logic [31:0] d);
    RegWriteWB = 1'b1; WriteRegWB = r; ResultWB = d;
  endtask
  task automatic iss_a(input logic [4:0] r);
    IssueDA = 1'b1; DestDA = r;
  endtask
  task automatic iss_b(input logic [4:0] r);
    IssueDB = 1'b1; DestDB = r;
  endtask

  initial begin
    logic [31:0] exp_v;
    // Every write is paired with an issue to the same register, so counters net to zero.
    tbl[0] = '{1'b1, 5'd1,  32'h12345678, 1'b1, 5'd2,  32'hCAFEF00D, 5'd1,  5'd2,  32'h12345678, 32'hCAFEF00D};
    tbl[1] = '{1'b1, 5'd3,  32'hA5A5A5A5, 1'b0, 5'd0,  32'h0,        5'd3,  5'd1,  32'hA5A5A5A5, 32'h12345678};
    tbl[2] = '{1'b1, 5'd8,  32'h11111111, 1'b1, 5'd8,  32'h22222222, 5'd8,  5'd8,  32'h22222222, 32'h22222222};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd31, 32'h80000001, 5'd0,  5'd31, 32'h0,        32'h80000001};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h0F0F0F0F, 5'd3,  5'd2,  32'h0F0F0F0F, 32'hCAFEF00D};
    tbl[5] = '{1'b1, 5'd31, 32'h00000001, 1'b1, 5'd30, 32'h00000002, 5'd31, 5'd30, 32'h00000001, 32'h00000002};

    idle();
    WriteRegWA = '0; WriteRegWB = '0; ResultWA = '0; ResultWB = '0;
    DestDA = '0; DestDB = '0;
    RsDA = '0; RtDA = '0; RsDB = '0; RtDB = '0;

    // Reset state
    #12;
    rd(5'd5);
    chk("rst_rd", RD1DA, 32'h0);
    chk("rst_busy", 32'(BusyRsDA), 32'h0);
    chk("rst_ovf", 32'(Overflow), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      RegWriteWA = tbl[i].wea; WriteRegWA = tbl[i].wa; ResultWA = tbl[i].da;
      IssueDA    = tbl[i].wea; DestDA     = tbl[i].wa;
      RegWriteWB = tbl[i].web; WriteRegWB = tbl[i].wb; ResultWB = tbl[i].db;
      IssueDB    = tbl[i].web; DestDB     = tbl[i].wb;
      step();
      RsDA = tbl[i].ra; RtDB = tbl[i].rb;
      #1;
      chk($sformatf("tbl%0d_a", i), RD1DA, tbl[i].exp_a);
      chk($sformatf("tbl%0d_b", i), RD2DB, tbl[i].exp_b);
    end
    chk("tbl_ovf", 32'(Overflow), 32'h0);

    // Two producers on r3, retired one at a time
    iss_a(5'd3); iss_b(5'd3);
    step();
    rd(5'd3);
    chk("sb_busy2", 32'(BusyRsDA), 32'h1);
    wr_a(5'd3, 32'h33330001);
    rd(5'd3);
    chk("sb_wb1_same", 32'(BusyRtDA), 32'h1);
    step();
    rd(5'd3);
    chk("sb_busy1", 32'(BusyRsDB), 32'h1);
    wr_b(5'd3, 32'h33330002);
    rd(5'd3);
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h0;
`else
    exp_v = 32'h1;
`endif
    chk("sb_wb2_same", 32'(BusyRtDB), exp_v);
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h33330002;
`else
    exp_v = 32'h33330001;
`endif
    chk("sb_wb2_rd_same", RD2DB, exp_v);
    step();
    rd(5'd3);
    chk("sb_busy0", 32'(BusyRsDA), 32'h0);
    chk("sb_rd", RD1DA, 32'h33330002);

    // Issue and write-back on r7 in one cycle with one producer pending
    iss_a(5'd7);
    step();
    iss_b(5'd7); wr_a(5'd7, 32'h77770007);
    rd(5'd7);
`ifdef REGFILE_BYPASS_EN
    exp_v = 32'h77770007;
`else
    exp_v = 32'h0;
`endif
    chk("r7_rd_same", RD1DA, exp_v);
    step();
    rd(5'd7);
    chk("r7_busy", 32'(BusyRsDA), 32'h1);
    chk("r7_rd", RD2DA, 32'h77770007);
    wr_b(5'd7, 32'h00000007);
    step();
    rd(5'd7);
    chk("r7_idle", 32'(BusyRtDA), 32'h0);
    chk("r7_rd2", RD1DB, 32'h00000007);

    // Register 0: writes and issues ignored
    wr_a(5'd0, 32'hFFFFFFFF); iss_a(5'd0); iss_b(5'd0);
    rd(5'd0);
    chk("r0_rd_same", RD1DA, 32'h0);
    step();
    rd(5'd0);
    chk("r0_rd", RD2DB, 32'h0);
    chk("r0_busy", 32'(BusyRsDA), 32'h0);
    chk("r0_ovf", 32'(Overflow), 32'h0);

    // Eight producers on r9 wrap the 3-bit counter
    for (int k = 0; k < 7; k++) begin
      iss_a(5'd9);
      step();
    end
    rd(5'd9);
    chk("ovf_busy7", 32'(BusyRsDA), 32'h1);
    chk("ovf_flag7", 32'(Overflow), 32'h0);
    iss_a(5'd9);
    step();
    rd(5'd9);
    chk("ovf_busy8", 32'(BusyRsDA), 32'h0);
    chk("ovf_flag8", 32'(Overflow), 32'h1);
    step();
    step();
    chk("ovf_sticky", 32'(Overflow), 32'h1);

    // Reset in the middle of activity on r5
    wr_a(5'd5, 32'hDEADBEEF); iss_a(5'd5);
    step();
    iss_b(5'd5);
    step();
    rd(5'd5);
    chk("mid_pre_rd", RD1DA, 32'hDEADBEEF);
    chk("mid_pre_busy", 32'(BusyRsDA), 32'h1);
    iss_a(5'd5); wr_b(5'd5, 32'h12345678);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rd", RD1DA, 32'h0);
    chk("mid_busy", 32'(BusyRsDA), 32'h0);
    chk("mid_ovf", 32'(Overflow), 32'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    step();
    rd(5'd5);
    chk("post_rd", RD2DA, 32'h0);
    chk("post_busy", 32'(BusyRtDB), 32'h0);
    chk("post_ovf", 32'(Overflow), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dual_issue_regfile.md
# dual_issue_regfile

Dual-issue architectural register file with pending-write scoreboard, sitting between the decode stage (reader) and the write-back stage (writer) of the two-lane pipeline. Accepts up to two register writes per cycle from write-back lanes A and B, serves four combinational operand reads to decode lanes A and B, and tracks per-register in-flight producers so the hazard unit can stall dependent instructions.

## Interface
Parameters:
- `CNT_W`, 3, width of per-register pending-write counter (max 2^CNT_W−1 in-flight producers per register)

Ports:
- `clk` in 1: clock, all state updates on rising edge
- `reset` in 1: asynchronous, active-high; clears all registers and counters
- `RegWriteWA`, `RegWriteWB` in 1: write enables from write-back lanes A/B
- `WriteRegWA`, `WriteRegWB` in 5: destination register, lanes A/B
- `ResultWA`, `ResultWB` in 32: write data, lanes A/B
- `RsDA`, `RtDA`, `RsDB`, `RtDB` in 5: decode read addresses
- `RD1DA`, `RD2DA`, `RD1DB`, `RD2DB` out 32: read data for Rs/Rt of lanes A/B
- `BusyRsDA`, `BusyRtDA`, `BusyRsDB`, `BusyRtDB` out 1: operand has an outstanding producer
- `IssueDA`, `IssueDB` in 1: lane instruction leaves decode this cycle and will write its dest (already qualified by stall/RegWrite)
- `DestDA`, `DestDB` in 5: destination of issuing instruction
- `Overflow` out 1: sticky error flag, pending counter wrapped

## Operation
- Storage: 32×32 registers; register 0 reads 0 always; writes and issues to register 0 ignored (no counter change).
- Write: on rising edge, `RegWriteWx` stores `ResultWx` to `WriteRegWx`. Same destination on both lanes: lane B value stored (B is younger).
- Read: combinational, stored value, subject to bypass (see Configuration).
- Scoreboard: per register r, `cnt[r]` next = cnt + (IssueDA&&DestDA==r) + (IssueDB&&DestDB==r) − (RegWriteWA&&WriteRegWA==r) − (RegWriteWB&&WriteRegWB==r); all four terms apply in the same cycle, net delta −2..+2.
- Busy for an address: `cnt[addr] != 0` (minus same-cycle writebacks when bypass compiled in); address 0 never busy.
- Overflow: increment past 2^CNT_W−1 or decrement below 0 sets `Overflow`; counter wraps modulo 2^CNT_W; flag cleared only by reset.
- No flush input: only instructions that issued are counted, and issued instructions always reach write-back.

## Timing
- Reset: all registers 0, all counters 0, `Overflow` 0; all Rd outputs 0 and all Busy outputs 0 while reset asserted, regardless of clock; reset mid-cycle discards in-progress issue/write.
- Write latency: stored value visible on read ports the cycle after the write edge (0 cycles with bypass).
- Issue to busy: busy asserted the cycle after the issue edge.
- Writeback to not-busy: counter decremented at the write edge; 0-cycle visibility with bypass.
- Issue and writeback to same register in same cycle: counter unchanged (net 0), busy unchanged.

## Configuration
- `REGFILE_BYPASS_EN` defined: read of r while `RegWriteWx` targets r in the same cycle returns `ResultWx` (B priority over A); busy for r computed as cnt[r] minus same-cycle writebacks to r.
- Not defined: reads return stored values only; busy from registered counter only; hazard unit stalls one extra cycle after write-back.

## Test plan
- Reset mid-operation: write 0xDEADBEEF to r5, issue to r5, assert reset -> RD of r5 = 0, BusyRs(r5) = 0, `Overflow` = 0 immediately.
- Dual write same reg: A writes 0x11111111, B writes 0x22222222 to r8 -> next cycle RD1DA(r8) = 0x22222222; with bypass, same cycle also 0x22222222.
- Register 0: write 0xFFFFFFFF to r0 and issue to r0 -> RD(r0) = 0, Busy(r0) = 0, no counter change.
- Scoreboard: issue A and B both to r3, then one writeback -> busy stays 1; second writeback -> busy 0 (next cycle without bypass, same cycle with).
- Simultaneous issue+writeback on r7 with cnt=1 -> cnt remains 1, busy stays 1, RD(r7) = written value next cycle.
- Overflow (CNT_W=3): 8 issues to r9 with no writeback -> `Overflow` = 1 after eighth edge, busy for r9 = 0 (wrapped), flag stays 1 until reset.
